// File: rtl/axi_lite_arbiter.sv
// axi_lite_arbiter: round-robin arbiter sharing one AXI4-Lite master port
// among NREQ single-beat register requesters, one transaction at a time.
//
// Ports:
//   clk, xrst              clock, asynchronous active-high reset
//   req/we/addr/wdata      per-requester request level, direction, packed
//                          address and write data (requester i at slice i)
//   ack                    one-cycle completion pulse to the grantee
//   rdata_o, resp_o        read data / response code, valid with ack
//   busy, gnt_id           transaction in progress, current/last grantee
//   aw*/w*/b*              AXI4-Lite write channels
//   ar*/r*                 AXI4-Lite read channels
module axi_lite_arbiter #(
    parameter int NREQ    = 4,
    parameter int REQ_BIT = $clog2(NREQ),
    parameter int DWIDTH  = 32,
    parameter int REGSIZE = 32
) (
    input  logic                    clk,
    input  logic                    xrst,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ-1:0]         we,
    input  logic [NREQ*REGSIZE-1:0] addr,
    input  logic [NREQ*DWIDTH-1:0]  wdata,
    output logic [NREQ-1:0]         ack,
    output logic [DWIDTH-1:0]       rdata_o,
    output logic [1:0]              resp_o,
    output logic                    busy,
    output logic [REQ_BIT-1:0]      gnt_id,
    output logic                    awvalid,
    input  logic                    awready,
    output logic [REGSIZE-1:0]      awaddr,
    output logic [2:0]              awprot,
    output logic                    wvalid,
    input  logic                    wready,
    output logic [DWIDTH-1:0]       wdata_m,
    output logic [DWIDTH/8-1:0]     wstrb,
    input  logic                    bvalid,
    output logic                    bready,
    input  logic [1:0]              bresp,
    output logic                    arvalid,
    input  logic                    arready,
    output logic [REGSIZE-1:0]      araddr,
    output logic [2:0]              arprot,
    input  logic                    rvalid,
    output logic                    rready,
    input  logic [DWIDTH-1:0]       rdata,
    input  logic [1:0]              rresp
);

    localparam int CW = REQ_BIT + 1;

    typedef enum logic [2:0] {
        IDLE,
        WADDR,
        WRESP,
        RADDR,
        RRESP,
        ACK
    } state_t;

    state_t               state_q, state_d;
    logic [REQ_BIT-1:0]   gnt_q, gnt_d;
    logic [REQ_BIT-1:0]   last_q, last_d;
    logic [REGSIZE-1:0]   addr_q, addr_d;
    logic [DWIDTH-1:0]    wdat_q, wdat_d;
    logic                 awvalid_q, awvalid_d;
    logic                 wvalid_q, wvalid_d;
    logic                 bready_q, bready_d;
    logic                 arvalid_q, arvalid_d;
    logic                 rready_q, rready_d;
    logic [NREQ-1:0]      ack_q, ack_d;
    logic                 busy_q, busy_d;
    logic [DWIDTH-1:0]    rdata_q, rdata_d;
    logic [1:0]           resp_q, resp_d;

    logic                 found;
    logic [REQ_BIT-1:0]   win;
    logic [CW-1:0]        cand;

    // Scan from last_gnt+1 upward with wrap, so the previous grantee
    // is looked at last and therefore has the lowest priority.
    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
        for (int i = 1; i <= NREQ; i++) begin
            cand = {1'b0, last_q} + CW'(i);
            if (cand >= CW'(NREQ)) begin
                cand = cand - CW'(NREQ);
            end
            if (!found && req[cand[REQ_BIT-1:0]]) begin
                found = 1'b1;
                win   = cand[REQ_BIT-1:0];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        last_d    = last_q;
        addr_d    = addr_q;
        wdat_d    = wdat_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        bready_d  = bready_q;
        arvalid_d = arvalid_q;
        rready_d  = rready_q;
        ack_d     = '0;
        busy_d    = busy_q;
        rdata_d   = rdata_q;
        resp_d    = resp_q;

        unique case (state_q)
            IDLE: begin
                if (found) begin
                    gnt_d  = win;
                    addr_d = addr[win*REGSIZE +: REGSIZE];
                    wdat_d = wdata[win*DWIDTH +: DWIDTH];
                    busy_d = 1'b1;
                    if (we[win]) begin
                        state_d   = WADDR;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end else begin
                        state_d   = RADDR;
                        arvalid_d = 1'b1;
                    end
                end
            end
            WADDR: begin
                // Address and data channels retire independently.
                if (awvalid_q && awready) begin
                    awvalid_d = 1'b0;
                end
                if (wvalid_q && wready) begin
                    wvalid_d = 1'b0;
                end
                if (!awvalid_d && !wvalid_d) begin
                    state_d  = WRESP;
                    bready_d = 1'b1;
                end
            end
            WRESP: begin
                if (bvalid) begin
                    state_d       = ACK;
                    bready_d      = 1'b0;
                    resp_d        = bresp;
                    ack_d[gnt_q]  = 1'b1;
                end
            end
            RADDR: begin
                if (arready) begin
                    state_d   = RRESP;
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                end
            end
            RRESP: begin
                if (rvalid) begin
                    state_d      = ACK;
                    rready_d     = 1'b0;
                    rdata_d      = rdata;
                    resp_d       = rresp;
                    ack_d[gnt_q] = 1'b1;
                end
            end
            ACK: begin
                // No grant here: the requester needs this cycle to
                // see its ack and drop req before arbitration resumes.
                state_d = IDLE;
                last_d  = gnt_q;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge xrst) begin
        if (xrst) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            last_q    <= REQ_BIT'(NREQ - 1);
            addr_q    <= '0;
            wdat_q    <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            ack_q     <= '0;
            busy_q    <= 1'b0;
            rdata_q   <= '0;
            resp_q    <= '0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            last_q    <= last_d;
            addr_q    <= addr_d;
            wdat_q    <= wdat_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            bready_q  <= bready_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            ack_q     <= ack_d;
            busy_q    <= busy_d;
            rdata_q   <= rdata_d;
            resp_q    <= resp_d;
        end
    end

    assign ack     = ack_q;
    assign rdata_o = rdata_q;
    assign resp_o  = resp_q;
    assign busy    = busy_q;
    assign gnt_id  = gnt_q;
    assign awvalid = awvalid_q;
    assign awaddr  = addr_q;
    assign awprot  = 3'b000;
    assign wvalid  = wvalid_q;
    assign wdata_m = wdat_q;
    assign wstrb   = '1;
    assign bready  = bready_q;
    assign arvalid = arvalid_q;
    assign araddr  = addr_q;
    assign arprot  = 3'b000;
    assign rready  = rready_q;

endmodule

// File: tb/tb_axi_lite_arbiter.sv
// tb_axi_lite_arbiter: directed bench for axi_lite_arbiter with a
// simple AXI4-Lite slave answering on the cycle after each handshake.
module tb_axi_lite_arbiter;

    localparam int NREQ = 4;
    localparam int RB   = 2;
    localparam int DW   = 32;
    localparam int AW   = 32;

    logic               clk = 1'b0;
    logic               xrst;
    logic [NREQ-1:0]    req;
    logic [NREQ-1:0]    we;
    logic [NREQ*AW-1:0] addr;
    logic [NREQ*DW-1:0] wdata;
    logic [NREQ-1:0]    ack;
    logic [DW-1:0]      rdata_o;
    logic [1:0]         resp_o;
    logic               busy;
    logic [RB-1:0]      gnt_id;
    logic               awvalid, awready;
    logic [AW-1:0]      awaddr;
    logic [2:0]         awprot;
    logic               wvalid, wready;
    logic [DW-1:0]      wdata_m;
    logic [DW/8-1:0]    wstrb;
    logic               bvalid, bready;
    logic [1:0]         bresp;
    logic               arvalid, arready;
    logic [AW-1:0]      araddr;
    logic [2:0]         arprot;
    logic               rvalid, rready;
    logic [DW-1:0]      rdata;
    logic [1:0]         rresp;

    logic [1:0]  bresp_cfg;
    logic        rhold;
    logic [31:0] rd_val;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    axi_lite_arbiter #(
        .NREQ    (NREQ),
        .REQ_BIT (RB),
        .DWIDTH  (DW),
        .REGSIZE (AW)
    ) dut (
        .clk     (clk),
        .xrst    (xrst),
        .req     (req),
        .we      (we),
        .addr    (addr),
        .wdata   (wdata),
        .ack     (ack),
        .rdata_o (rdata_o),
        .resp_o  (resp_o),
        .busy    (busy),
        .gnt_id  (gnt_id),
        .awvalid (awvalid),
        .awready (awready),
        .awaddr  (awaddr),
        .awprot  (awprot),
        .wvalid  (wvalid),
        .wready  (wready),
        .wdata_m (wdata_m),
        .wstrb   (wstrb),
        .bvalid  (bvalid),
        .bready  (bready),
        .bresp   (bresp),
        .arvalid (arvalid),
        .arready (arready),
        .araddr  (araddr),
        .arprot  (arprot),
        .rvalid  (rvalid),
        .rready  (rready),
        .rdata   (rdata),
        .rresp   (rresp)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // One cycle: move to the falling edge, then let the slave answer
    // a response-ready with valid in the same cycle.
    task automatic step();
        @(negedge clk);
        bvalid = bready;
        bresp  = bready ? bresp_cfg : 2'b00;
        rvalid = rready && !rhold;
        rdata  = rd_val;
        rresp  = 2'b00;
    endtask

    task automatic set_rq(input int i, input logic w,
                          input logic [31:0] a, input logic [31:0] d);
        we[i]             = w;
        addr[i*AW +: AW]  = a;
        wdata[i*DW +: DW] = d;
        req[i]            = 1'b1;
    endtask

    task automatic do_reset();
        xrst = 1'b1;
        step();
        step();
        xrst = 1'b0;
    endtask

    task automatic wait_ack(output int id, output int n);
        id = -1;
        n  = 0;
        while (n < 20 && id < 0) begin
            step();
            n++;
            for (int k = 0; k < NREQ; k++) begin
                if (ack[k]) id = k;
            end
        end
    endtask

    initial begin
        int id;
        int n;
        int exp_ord[7];
        exp_ord = '{0, 1, 2, 3, 0, 2, 0};

        xrst      = 1'b1;
        req       = '0;
        we        = '0;
        addr      = '0;
        wdata     = '0;
        awready   = 1'b1;
        wready    = 1'b1;
        arready   = 1'b1;
        bvalid    = 1'b0;
        bresp     = 2'b00;
        rvalid    = 1'b0;
        rdata     = '0;
        rresp     = 2'b00;
        bresp_cfg = 2'b00;
        rhold     = 1'b0;
        rd_val    = '0;

        // reset state
        step();
        step();
        check("rst_ack", 32'(ack), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_gnt", 32'(gnt_id), 32'h0);
        check("rst_resp", 32'(resp_o), 32'h0);
        check("rst_rdata", rdata_o, 32'h0);
        check("rst_valids",
              32'({awvalid, wvalid, bready, arvalid, rready}), 32'h0);
        check("rst_awaddr", awaddr, 32'h0);
        check("rst_wdata_m", wdata_m, 32'h0);
        check("rst_prot", 32'({awprot, arprot}), 32'h0);
        check("wstrb", 32'(wstrb), 32'hF);
        xrst = 1'b0;
        step();

        // single write, always-ready slave
        set_rq(0, 1'b1, 32'h10, 32'hA5A5A5A5);
        step();
        check("wr_c1_aw_w", 32'({awvalid, wvalid}), 32'h3);
        check("wr_c1_awaddr", awaddr, 32'h10);
        check("wr_c1_wdata", wdata_m, 32'hA5A5A5A5);
        check("wr_c1_busy", 32'(busy), 32'h1);
        check("wr_c1_gnt", 32'(gnt_id), 32'h0);
        check("wr_c1_ar", 32'(arvalid), 32'h0);
        step();
        check("wr_c2_bready", 32'(bready), 32'h1);
        check("wr_c2_aw_w", 32'({awvalid, wvalid}), 32'h0);
        check("wr_c2_ack", 32'(ack), 32'h0);
        step();
        check("wr_c3_ack", 32'(ack), 32'h1);
        check("wr_c3_resp", 32'(resp_o), 32'h0);
        check("wr_c3_busy", 32'(busy), 32'h1);
        req[0] = 1'b0;
        step();
        check("wr_c4_ack", 32'(ack), 32'h0);
        check("wr_c4_busy", 32'(busy), 32'h0);

        // single read from requester 2
        rd_val = 32'h12345678;
        set_rq(2, 1'b0, 32'h20, 32'h0);
        step();
        check("rd_c1_ar", 32'(arvalid), 32'h1);
        check("rd_c1_araddr", araddr, 32'h20);
        check("rd_c1_aw_w", 32'({awvalid, wvalid}), 32'h0);
        check("rd_c1_gnt", 32'(gnt_id), 32'h2);
        step();
        check("rd_c2_rready", 32'(rready), 32'h1);
        check("rd_c2_ar", 32'(arvalid), 32'h0);
        step();
        check("rd_c3_ack", 32'(ack), 32'h4);
        check("rd_c3_rdata", rdata_o, 32'h12345678);
        check("rd_c3_resp", 32'(resp_o), 32'h0);
        check("rd_c3_aw_w", 32'({awvalid, wvalid, bready}), 32'h0);
        req[2] = 1'b0;
        step();
        check("rd_c4_ack", 32'(ack), 32'h0);

        // round-robin fairness from reset
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            set_rq(i, 1'b0, 32'h100 + 32'(i * 4), 32'h0);
        end
        for (int k = 0; k < 7; k++) begin
            wait_ack(id, n);
            check($sformatf("rr_id%0d", k), 32'(id), 32'(exp_ord[k]));
            check($sformatf("rr_gnt%0d", k), 32'(gnt_id),
                  32'(exp_ord[k]));
            check($sformatf("rr_lat%0d", k), 32'(n), (k == 0) ? 32'd3
                                                               : 32'd4);
            if (k == 4) begin
                req = 4'b0101;
            end
        end
        req = '0;
        step();
        check("rr_idle_busy", 32'(busy), 32'h0);

        // split handshakes: data channel late by three cycles
        wready = 1'b0;
        set_rq(1, 1'b1, 32'h44, 32'hDEADBEEF);
        step();
        check("sp_c1_aw_w", 32'({awvalid, wvalid}), 32'h3);
        step();
        check("sp_c2_aw_w", 32'({awvalid, wvalid}), 32'h1);
        check("sp_c2_bready", 32'(bready), 32'h0);
        step();
        check("sp_c3_aw_w", 32'({awvalid, wvalid}), 32'h1);
        check("sp_c3_bready", 32'(bready), 32'h0);
        step();
        check("sp_c4_w", 32'(wvalid), 32'h1);
        check("sp_c4_wdata", wdata_m, 32'hDEADBEEF);
        wready = 1'b1;
        step();
        check("sp_c5_w", 32'(wvalid), 32'h0);
        check("sp_c5_bready", 32'(bready), 32'h1);
        check("sp_c5_ack", 32'(ack), 32'h0);
        step();
        check("sp_c6_ack", 32'(ack), 32'h2);
        req[1] = 1'b0;
        step();
        check("sp_c7_ack", 32'(ack), 32'h0);

        // error response, then a queued read proceeds
        bresp_cfg = 2'b10;
        rd_val    = 32'hCAFEF00D;
        set_rq(3, 1'b1, 32'h30, 32'h55);
        set_rq(0, 1'b0, 32'h34, 32'h0);
        wait_ack(id, n);
        check("err_id", 32'(id), 32'h3);
        check("err_lat", 32'(n), 32'd3);
        check("err_resp", 32'(resp_o), 32'h2);
        req[3]    = 1'b0;
        bresp_cfg = 2'b00;
        wait_ack(id, n);
        check("err_next_id", 32'(id), 32'h0);
        check("err_next_lat", 32'(n), 32'd4);
        check("err_next_resp", 32'(resp_o), 32'h0);
        check("err_next_rdata", rdata_o, 32'hCAFEF00D);
        req[0] = 1'b0;
        step();

        // reset while waiting for read data
        rhold  = 1'b1;
        rd_val = 32'h0BADC0DE;
        set_rq(1, 1'b0, 32'h50, 32'h0);
        step();
        step();
        step();
        check("mr_pre_rready", 32'(rready), 32'h1);
        check("mr_pre_busy", 32'(busy), 32'h1);
        xrst = 1'b1;
        #1;
        check("mr_rready", 32'(rready), 32'h0);
        check("mr_arvalid", 32'(arvalid), 32'h0);
        check("mr_busy", 32'(busy), 32'h0);
        check("mr_gnt", 32'(gnt_id), 32'h0);
        step();
        check("mr_ack", 32'(ack), 32'h0);
        step();
        xrst  = 1'b0;
        rhold = 1'b0;
        wait_ack(id, n);
        check("mr_after_id", 32'(id), 32'h1);
        check("mr_after_lat", 32'(n), 32'd3);
        check("mr_after_rdata", rdata_o, 32'h0BADC0DE);
        req[1] = 1'b0;
        step();
        check("mr_after_busy", 32'(busy), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/axi_lite_arbiter.md
# axi_lite_arbiter

Round-robin arbiter that shares a single AXI4-Lite master port among NREQ local requesters, each issuing single-beat register reads or writes. It sits between the register-access clients of a design and the AXI4-Lite interconnect. It runs exactly one transaction at a time, returns read data and response code to the granted requester, and pulses that requester's ack on completion.

## Interface
Parameters:
- NREQ, 4, number of requesters (≥2)
- REQ_BIT, clogb2(NREQ), width of grant index
- DWIDTH, 32, AXI data width
- REGSIZE, 32, AXI address width

Ports:
- clk  in  1  clock; all logic on rising edge
- xrst  in  1  reset, asynchronous, active-high (1 = reset)
- req  in  NREQ  per-requester request level; held until own ack
- we  in  NREQ  per-requester direction: 1 = write, 0 = read
- addr  in  NREQ*REGSIZE  packed addresses; requester i at [i*REGSIZE +: REGSIZE]
- wdata  in  NREQ*DWIDTH  packed write data, same packing
- ack  out  NREQ  one-cycle completion pulse to the granted requester
- rdata_o  out  DWIDTH  read data; valid while ack is high
- resp_o  out  2  bresp/rresp of the completed transaction; valid while ack is high
- busy  out  1  high from grant until the ack cycle, inclusive
- gnt_id  out  REQ_BIT  index of the current or most recent grantee
- awvalid, awaddr[REGSIZE], awprot[3], wvalid, wdata_m[DWIDTH], wstrb[DWIDTH/8], bready: write channels (out); awready, wready, bvalid, bresp[2] (in)
- arvalid, araddr[REGSIZE], arprot[3], rready: read channels (out); arready, rvalid, rdata[DWIDTH], rresp[2] (in)

## Operation
- States: IDLE, WADDR, WRESP, RADDR, RRESP, ACK.
- IDLE: if any req bit is set, choose a winner round-robin. Search starts at last_gnt+1 and wraps modulo NREQ. Latch winner index, addr, wdata, and we. Go to WADDR if we=1, else RADDR. No request means stay in IDLE.
- WADDR: awvalid and wvalid both high. Each drops independently on its own handshake (valid&&ready); both may complete in the same cycle. Go to WRESP after both handshakes have completed.
- WRESP: bready=1. On bvalid, latch bresp and go to ACK.
- RADDR: arvalid=1 until arready. Then go to RRESP.
- RRESP: rready=1. On rvalid, latch rdata and rresp and go to ACK.
- ACK: ack[gnt_id]=1 for exactly one cycle. Update last_gnt to gnt_id. Return to IDLE. No new grant is made in the ACK cycle.
- Fixed outputs: awprot=arprot=3'b000; wstrb all ones. awaddr/araddr/wdata_m hold the latched values for the whole transaction.
- A requester that drops req after its grant still has its transaction completed and acked. A req bit that drops before it wins is simply not considered.
- resp_o errors (bit1 set) are passed through and do not change the sequence.
- Round-robin rule: the requester granted last has the lowest priority next time. After reset last_gnt = NREQ-1, so requester 0 has top priority.
- Out-of-order slave responses (bvalid before both handshakes) are not expected. bvalid/rvalid are ignored outside WRESP/RRESP.

## Timing
- Reset (asynchronous, any state): state=IDLE; ack=0, busy=0, gnt_id=0, resp_o=0, rdata_o=0; all valid/ready outputs=0; addresses/wdata_m=0; last_gnt=NREQ-1. A transaction in flight is abandoned and is not acked.
- Minimum write latency, with the slave always ready and bvalid one cycle after the handshakes: req sampled at edge 0; awvalid/wvalid high in cycle 1; bready in cycle 2; ack in cycle 3.
- Minimum read latency follows the same pattern: arvalid cycle 1, rready cycle 2, ack cycle 3.
- Next grant is sampled in the cycle after ack, so the back-to-back issue interval is 4 cycles minimum.
- All outputs are registered. No combinational path exists from AXI inputs to AXI outputs.

## Test plan
- Single write: req[0]=1, we[0]=1, addr0=0x10, wdata0=0xA5A5A5A5, slave ready -> awaddr=0x10 and wdata_m=0xA5A5A5A5 handshake in cycle 1; ack[0] in cycle 3 with resp_o=0; busy high cycles 1–3.
- Single read: req[2]=1, we[2]=0, addr2=0x20, slave returns rdata=0x12345678 with rresp=0 -> ack[2] pulse with rdata_o=0x12345678; no aw/w activity.
- Round-robin fairness: req=4'b1111 held after reset, all reads -> grant order 0,1,2,3,0. Then req=4'b0101 after grant 0 -> next grants 2,0.
- Split handshakes: wready delayed 3 cycles after awready -> awvalid drops after its handshake, wvalid stays high until wready; WRESP entered only after both; single ack.
- Error response: slave returns bresp=2'b10 -> ack pulses with resp_o=2'b10; the next queued request proceeds normally.
- Reset mid-transaction: xrst asserted while in RRESP -> rready, arvalid, and busy drop immediately with no ack. After release, a pending req[1] is granted and completes normally.
